// File: rtl/cpu_run_ctrl_if.sv
// Command, breakpoint, retire and pulse signals between the monitor side and cpu_run_ctrl.
// The master drives commands and retire info; the slave (run controller) drives the pulses and status.
interface cpu_run_ctrl_if #(
   parameter int STEP_W = 16
) ();
   logic              init_calib_complete;
   logic              cmd_run;
   logic              cmd_step;
   logic              cmd_stop;
   logic [STEP_W-1:0] step_count;
   logic              brk_en;
   logic [31:0]       brk_addr;
   logic              retire_valid;
   logic [31:0]       retire_pc;
   logic              stall;
   logic              cpu_start;
   logic              quit_cmd;
   logic              busy;
   logic [2:0]        halt_cause;
   logic [STEP_W-1:0] steps_left;

   modport master (
      output init_calib_complete, cmd_run, cmd_step, cmd_stop, step_count,
             brk_en, brk_addr, retire_valid, retire_pc, stall,
      input  cpu_start, quit_cmd, busy, halt_cause, steps_left
   );

   modport slave (
      input  init_calib_complete, cmd_run, cmd_step, cmd_stop, step_count,
             brk_en, brk_addr, retire_valid, retire_pc, stall,
      output cpu_start, quit_cmd, busy, halt_cause, steps_left
   );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: turns run/step/stop commands into single-cycle cpu_start / quit_cmd
// pulses, with instruction-count stepping, one PC breakpoint, calibration wait and pipeline drain.
module cpu_run_ctrl #(
   parameter int STEP_W      = 16,
   parameter int DRAIN_CYC   = 6,
   parameter int CAL_TIMEOUT = 0
) (
   input  logic          clk,
   input  logic          rst,
   cpu_run_ctrl_if.slave bus
);
   localparam int TIMER_W = 32;

   typedef enum logic [2:0] {IDLE, WAIT_CAL, START, RUN, QUIT, DRAIN} state_t;
   typedef enum logic [2:0] {
      CAUSE_NONE = 3'd0, CAUSE_STOP = 3'd1, CAUSE_STEP = 3'd2, CAUSE_BRK = 3'd3, CAUSE_CAL = 3'd4
   } cause_t;

   state_t             state, state_nxt;
   cause_t             cause, cause_nxt;
   logic               step_mode, step_mode_nxt;
   logic [STEP_W-1:0]  steps, steps_nxt;
   logic [TIMER_W-1:0] timer, timer_nxt;
   logic               cal_q;
   logic               start_q, quit_q, busy_q;
   logic               start_nxt, quit_nxt, busy_nxt;

   logic              retire_ok, brk_hit, last_step, cal_expired, drain_done;
   logic [STEP_W-1:0] step_load;

   assign retire_ok   = bus.retire_valid & ~bus.stall;
   assign brk_hit     = retire_ok & bus.brk_en & (bus.retire_pc == bus.brk_addr);
   assign last_step   = retire_ok & step_mode & (steps == STEP_W'(1));
   assign step_load   = (bus.step_count == '0) ? STEP_W'(1) : bus.step_count;
   assign cal_expired = (CAL_TIMEOUT != 0) && (timer == TIMER_W'(CAL_TIMEOUT - 1));
   assign drain_done  = (timer == TIMER_W'(DRAIN_CYC - 1));

   // Calibration is registered once; every decision uses the flopped copy.
   // NOTE: sequential state only ever uses <=, so every flop sees pre-edge values of its peers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cause     <= CAUSE_NONE;
         step_mode <= 1'b0;
         steps     <= '0;
         timer     <= '0;
         cal_q     <= 1'b0;
         start_q   <= 1'b0;
         quit_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cause     <= cause_nxt;
         step_mode <= step_mode_nxt;
         steps     <= steps_nxt;
         timer     <= timer_nxt;
         cal_q     <= bus.init_calib_complete;
         start_q   <= start_nxt;
         quit_q    <= quit_nxt;
         busy_q    <= busy_nxt;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt     = state;
      cause_nxt     = cause;
      step_mode_nxt = step_mode;
      steps_nxt     = steps;
      case (state)
         IDLE: begin
            if (!bus.cmd_stop && (bus.cmd_step || bus.cmd_run)) begin
               step_mode_nxt = bus.cmd_step;
               steps_nxt     = bus.cmd_step ? step_load : '0;
               cause_nxt     = CAUSE_NONE;
               state_nxt     = cal_q ? START : WAIT_CAL;
            end
         end
         WAIT_CAL: begin
            if (bus.cmd_stop) begin
               state_nxt = IDLE;
               cause_nxt = CAUSE_STOP;
               steps_nxt = '0;
            end else if (cal_q) begin
               state_nxt = START;
            end else if (cal_expired) begin
               state_nxt = IDLE;
               cause_nxt = CAUSE_CAL;
               steps_nxt = '0;
            end
         end
         START: begin
            state_nxt = bus.cmd_stop ? QUIT : RUN;
            if (bus.cmd_stop) cause_nxt = CAUSE_STOP;
         end
         RUN: begin
            if (retire_ok && step_mode && steps != '0) steps_nxt = steps - STEP_W'(1);
            // Stop outranks a breakpoint, which outranks the final step.
            if (bus.cmd_stop) begin
               state_nxt = QUIT;
               cause_nxt = CAUSE_STOP;
            end else if (brk_hit) begin
               state_nxt = QUIT;
               cause_nxt = CAUSE_BRK;
            end else if (last_step) begin
               state_nxt = QUIT;
               cause_nxt = CAUSE_STEP;
            end
         end
         QUIT:  state_nxt = DRAIN;
         DRAIN: begin
            if (drain_done) begin
               state_nxt = IDLE;
               steps_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      timer_nxt = (state_nxt == state && (state == WAIT_CAL || state == DRAIN))
                  ? timer + TIMER_W'(1) : '0;
   end

   // The quit pulse is issued from the QUIT state and so lands on the first DRAIN cycle.
   always_comb begin
      start_nxt = (state_nxt == START);
      quit_nxt  = (state == QUIT);
      busy_nxt  = (state != IDLE);
   end

   assign bus.cpu_start  = start_q;
   assign bus.quit_cmd   = quit_q;
   assign bus.busy       = busy_q;
   assign bus.halt_cause = cause;
   assign bus.steps_left = steps;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized and directed bench for cpu_run_ctrl: a pulse scoreboard checked by a monitor,
// with expected pulses derived from a session-level model of the run-control rules.
module tb_cpu_run_ctrl;
   localparam int STEP_W = 16;

   logic clk = 1'b0;
   logic rst;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cpu_run_ctrl_if #(.STEP_W(STEP_W)) ifc ();
   cpu_run_ctrl_if #(.STEP_W(STEP_W)) ifc_to ();

   cpu_run_ctrl #(.STEP_W(STEP_W), .DRAIN_CYC(6), .CAL_TIMEOUT(0)) dut (
      .clk(clk), .rst(rst), .bus(ifc.slave)
   );
   cpu_run_ctrl #(.STEP_W(STEP_W), .DRAIN_CYC(6), .CAL_TIMEOUT(8)) dut_to (
      .clk(clk), .rst(rst), .bus(ifc_to.slave)
   );

   typedef struct {
      bit         is_quit;
      int         at;
      logic [2:0] cause;
   } pulse_t;
   pulse_t exp_q[$];

   // Retire stream for the next session.
   logic        rv [64];
   logic        st [64];
   logic [31:0] pcs[64];
   int          len;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input bit q, input int at, input logic [2:0] c);
      pulse_t p;
      p.is_quit = q;
      p.at      = at;
      p.cause   = c;
      exp_q.push_back(p);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ifc.cmd_run      = 1'b0;
      ifc.cmd_step     = 1'b0;
      ifc.cmd_stop     = 1'b0;
      ifc.retire_valid = 1'b0;
      ifc.stall        = 1'b0;
      ifc.retire_pc    = '0;
   endtask

   task automatic clear_stream(input int n);
      len = n;
      for (int k = 0; k < 64; k++) begin
         rv[k]  = 1'b0;
         st[k]  = 1'b0;
         pcs[k] = '0;
      end
   endtask

   task automatic set_ret(input int k, input logic v, input logic s, input logic [31:0] pc);
      rv[k]  = v;
      st[k]  = s;
      pcs[k] = pc;
   endtask

   // Monitor: pops the scoreboard on every pulse the DUT presents.
   initial begin : monitor
      pulse_t e;
      bit     prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) prev = 1'b0;
         else begin
            if (ifc.cpu_start || ifc.quit_cmd) begin
               check("pulse_spacing", {31'd0, prev}, 32'd0);
               check("pulse_exclusive", {31'd0, ifc.cpu_start & ifc.quit_cmd}, 32'd0);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_pulse: start=%0b quit=%0b with nothing expected (cycle %0d)",
                           ifc.cpu_start, ifc.quit_cmd, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check(e.is_quit ? "quit_kind" : "start_kind", {31'd0, ifc.quit_cmd}, {31'd0, e.is_quit});
                  check("pulse_cycle", cyc, e.at);
                  if (e.is_quit) check("quit_cause", {29'd0, ifc.halt_cause}, {29'd0, e.cause});
               end
            end
            prev = ifc.cpu_start | ifc.quit_cmd;
         end
      end
   end

   // One command session. stop_k: -1 = stop during START, else stream index of the stop.
   task automatic session(input bit step, input int sc, input bit be, input logic [31:0] ba,
                          input int stop_k);
      int         a, e, end_k, stop_eff, cnt, need, qbefore;
      logic [2:0] cause;
      need     = (sc == 0) ? 1 : sc;
      cnt      = 0;
      end_k    = -1;
      cause    = 3'd0;
      stop_eff = stop_k;
      if (stop_k < 0) cause = 3'd1;
      else begin
         for (int k = 0; k < len && end_k < 0; k++) begin
            if (k == stop_k) begin
               end_k = k;
               cause = 3'd1;
            end else if (rv[k] && !st[k]) begin
               if (step) cnt++;
               if (be && pcs[k] == ba) begin
                  end_k = k;
                  cause = 3'd3;
               end else if (step && cnt == need) begin
                  end_k = k;
                  cause = 3'd2;
               end
            end
         end
         if (end_k < 0) begin
            end_k    = len;
            stop_eff = len;
            cause    = 3'd1;
         end
      end

      idle_inputs();
      ifc.brk_en     = be;
      ifc.brk_addr   = ba;
      ifc.step_count = STEP_W'(sc);
      ifc.cmd_step   = step;
      ifc.cmd_run    = step ? 1'($urandom_range(0, 1)) : 1'b1;
      a = cyc;
      e = (stop_k < 0) ? a + 1 : a + 2 + end_k;
      push(1'b0, a + 1, 3'd0);
      push(1'b1, e + 2, cause);
      next();
      idle_inputs();
      ifc.step_count = STEP_W'($urandom);
      ifc.cmd_stop   = (stop_k < 0);
      qbefore = 0;
      if (stop_k >= 0) begin
         for (int k = 0; k <= end_k; k++) begin
            next();
            check("steps_left_run", {16'd0, ifc.steps_left}, step ? need - qbefore : 0);
            ifc.cmd_stop = (k == stop_eff);
            ifc.cmd_run  = ($urandom_range(0, 3) == 0);
            ifc.cmd_step = ($urandom_range(0, 3) == 0);
            if (k < len) begin
               ifc.retire_valid = rv[k];
               ifc.stall        = st[k];
               ifc.retire_pc    = pcs[k];
               if (rv[k] && !st[k]) qbefore++;
            end else begin
               ifc.retire_valid = 1'b0;
               ifc.stall        = 1'b0;
               ifc.retire_pc    = '0;
            end
         end
      end
      // QUIT then DRAIN: every command and retire thrown at it must be ignored.
      for (int i = 1; i <= 7; i++) begin
         next();
         if (i == 1 && cause == 3'd2) check("steps_left_done", {16'd0, ifc.steps_left}, 32'd0);
         ifc.cmd_run      = 1'($urandom_range(0, 1));
         ifc.cmd_step     = 1'($urandom_range(0, 1));
         ifc.cmd_stop     = 1'($urandom_range(0, 1));
         ifc.retire_valid = 1'($urandom_range(0, 1));
         ifc.retire_pc    = ba;
      end
      next();
      idle_inputs();
      check("busy_in_drain", {31'd0, ifc.busy}, 32'd1);
      next();
      check("busy_idle", {31'd0, ifc.busy}, 32'd0);
      check("cause_held", {29'd0, ifc.halt_cause}, {29'd0, cause});
      check("pending_pulses", exp_q.size(), 32'd0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : stim
      int a, r, pulses;
      rst = 1'b1;
      idle_inputs();
      ifc.init_calib_complete = 1'b1;
      ifc.step_count = '0;
      ifc.brk_en     = 1'b0;
      ifc.brk_addr   = '0;
      ifc_to.init_calib_complete = 1'b0;
      ifc_to.cmd_run      = 1'b0;
      ifc_to.cmd_step     = 1'b0;
      ifc_to.cmd_stop     = 1'b0;
      ifc_to.step_count   = '0;
      ifc_to.brk_en       = 1'b0;
      ifc_to.brk_addr     = '0;
      ifc_to.retire_valid = 1'b0;
      ifc_to.retire_pc    = '0;
      ifc_to.stall        = 1'b0;
      repeat (3) next();
      check("rst_start", {31'd0, ifc.cpu_start}, 32'd0);
      check("rst_quit", {31'd0, ifc.quit_cmd}, 32'd0);
      check("rst_busy", {31'd0, ifc.busy}, 32'd0);
      check("rst_cause", {29'd0, ifc.halt_cause}, 32'd0);
      check("rst_steps", {16'd0, ifc.steps_left}, 32'd0);
      rst = 1'b0;
      repeat (3) next();

      // Free run stopped by command.
      clear_stream(12);
      session(1'b0, 0, 1'b0, 32'h0, 8);
      // Step 3 with stalled retires interleaved.
      clear_stream(8);
      set_ret(0, 1, 1, 32'h10); set_ret(1, 1, 0, 32'h14); set_ret(3, 1, 1, 32'h18);
      set_ret(4, 1, 0, 32'h18); set_ret(5, 1, 1, 32'h1c); set_ret(6, 1, 0, 32'h1c);
      session(1'b1, 3, 1'b0, 32'h0, 99);
      // Step count 0 behaves as 1.
      clear_stream(6);
      set_ret(0, 1, 1, 32'h20); set_ret(2, 1, 0, 32'h24); set_ret(3, 1, 0, 32'h28);
      session(1'b1, 0, 1'b0, 32'h0, 99);
      // Breakpoint in free run, then the same stream with the breakpoint disabled.
      clear_stream(6);
      set_ret(0, 1, 0, 32'h3c); set_ret(1, 1, 0, 32'h40); set_ret(2, 1, 0, 32'h44);
      session(1'b0, 0, 1'b1, 32'h40, 99);
      session(1'b0, 0, 1'b0, 32'h40, 5);
      // Last step on the breakpoint, then with a stop in the same cycle.
      clear_stream(4);
      set_ret(0, 1, 0, 32'h40);
      session(1'b1, 1, 1'b1, 32'h40, 99);
      session(1'b1, 1, 1'b1, 32'h40, 0);
      // Stop while in START.
      session(1'b0, 0, 1'b0, 32'h0, -1);

      // Run and stop together in IDLE: ignored.
      ifc.cmd_run  = 1'b1;
      ifc.cmd_stop = 1'b1;
      next();
      idle_inputs();
      repeat (4) next();
      check("run_stop_ignored_busy", {31'd0, ifc.busy}, 32'd0);
      check("run_stop_ignored_pulses", exp_q.size(), 32'd0);

      // Wait for calibration with no timeout, then start.
      ifc.init_calib_complete = 1'b0;
      next();
      ifc.cmd_run = 1'b1;
      next();
      idle_inputs();
      repeat (20) next();
      check("wait_cal_busy", {31'd0, ifc.busy}, 32'd1);
      ifc.init_calib_complete = 1'b1;
      r = cyc;
      push(1'b0, r + 2, 3'd0);
      repeat (3) next();
      ifc.cmd_stop = 1'b1;
      push(1'b1, r + 5, 3'd1);
      next();
      idle_inputs();
      repeat (12) next();
      check("cal_run_busy", {31'd0, ifc.busy}, 32'd0);
      check("cal_run_pending", exp_q.size(), 32'd0);

      // Stop during the calibration wait: no pulses, cause stop.
      ifc.init_calib_complete = 1'b0;
      next();
      ifc.cmd_run = 1'b1;
      next();
      idle_inputs();
      repeat (3) next();
      check("accept_clears_cause", {29'd0, ifc.halt_cause}, 32'd0);
      ifc.cmd_stop = 1'b1;
      next();
      idle_inputs();
      repeat (3) next();
      check("wait_cal_stop_busy", {31'd0, ifc.busy}, 32'd0);
      check("wait_cal_stop_cause", {29'd0, ifc.halt_cause}, 32'd1);
      ifc.init_calib_complete = 1'b1;
      repeat (2) next();

      // Calibration timeout on the second instance.
      ifc_to.cmd_run = 1'b1;
      a = cyc;
      next();
      ifc_to.cmd_run = 1'b0;
      pulses = 0;
      for (int i = 2; i <= 12; i++) begin
         next();
         if (ifc_to.cpu_start || ifc_to.quit_cmd) pulses++;
         if (i == 8) check("timeout_busy_waiting", {31'd0, ifc_to.busy}, 32'd1);
         if (i == 10) begin
            check("timeout_busy_idle", {31'd0, ifc_to.busy}, 32'd0);
            check("timeout_cause", {29'd0, ifc_to.halt_cause}, 32'd4);
         end
      end
      check("timeout_no_pulses", pulses, 32'd0);
      check("timeout_started_at", cyc - a, 32'd12);

      // Reset while in QUIT: the quit pulse must never appear.
      ifc.cmd_run = 1'b1;
      a = cyc;
      push(1'b0, a + 1, 3'd0);
      next();
      idle_inputs();
      next();
      ifc.cmd_stop = 1'b1;
      next();
      idle_inputs();
      rst = 1'b1;
      next();
      rst = 1'b0;
      check("rst_quit_no_pulse", {31'd0, ifc.quit_cmd}, 32'd0);
      check("rst_quit_busy", {31'd0, ifc.busy}, 32'd0);
      repeat (3) next();
      check("rst_quit_pending", exp_q.size(), 32'd0);

      // Reset while in DRAIN: everything back to zero.
      ifc.cmd_step   = 1'b1;
      ifc.step_count = STEP_W'(5);
      a = cyc;
      push(1'b0, a + 1, 3'd0);
      push(1'b1, a + 4, 3'd1);
      next();
      idle_inputs();
      next();
      ifc.cmd_stop = 1'b1;
      next();
      idle_inputs();
      repeat (2) next();
      check("pre_rst_steps", {16'd0, ifc.steps_left}, 32'd5);
      rst = 1'b1;
      next();
      rst = 1'b0;
      check("rst_drain_start", {31'd0, ifc.cpu_start}, 32'd0);
      check("rst_drain_quit", {31'd0, ifc.quit_cmd}, 32'd0);
      check("rst_drain_busy", {31'd0, ifc.busy}, 32'd0);
      check("rst_drain_cause", {29'd0, ifc.halt_cause}, 32'd0);
      check("rst_drain_steps", {16'd0, ifc.steps_left}, 32'd0);
      repeat (3) next();

      // Randomized sessions.
      for (int n = 0; n < 40; n++) begin
         clear_stream(30);
         for (int k = 0; k < 30; k++)
            set_ret(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    32'h30 + 32'(4 * $urandom_range(0, 7)));
         session(1'($urandom_range(0, 1)), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                 32'h30 + 32'(4 * $urandom_range(0, 7)),
                 ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 40));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
